// File: rtl/cache_tag_mr_pkg.sv
// Shared types and helpers for the tag-addressed must-read buffer.
// Entry geometry lives here so the entry sub-module and the top agree on widths.
package cache_tag_mr_pkg;

    localparam int ENTRY_DATA_W = 16;
    localparam int ENTRY_TAG_W  = 8;
    localparam int ENTRY_DEPTH  = 8;
    localparam int IDX_W        = $clog2(ENTRY_DEPTH);
    localparam int CNT_W        = $clog2(ENTRY_DEPTH + 1);

    typedef struct packed {
        logic                    pending;
        logic [ENTRY_TAG_W-1:0]  tag;
        logic [ENTRY_DATA_W-1:0] data;
    } entry_t;

    // Scan from the top down so the last assignment wins with the lowest free index.
    function automatic logic [IDX_W-1:0] lowest_free_idx(input logic [ENTRY_DEPTH-1:0] pending);
        lowest_free_idx = '0;
        for (int i = ENTRY_DEPTH - 1; i >= 0; i--) begin
            if (!pending[i]) lowest_free_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/cache_tag_mr_entry.sv
// One buffer slot: stores tag/data while pending and compares against the
// lookup tag and the incoming write tag.
module cache_tag_mr_entry
    import cache_tag_mr_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [ENTRY_TAG_W-1:0]  wr_tag,
    input  logic [ENTRY_DATA_W-1:0] wr_data,
    input  logic                    consume,
    input  logic [ENTRY_TAG_W-1:0]  rd_tag,
    output logic                    pending,
    output logic                    rd_match,
    output logic                    wr_match,
    output logic [ENTRY_DATA_W-1:0] data
);

    entry_t entry;

    // wr_en only targets free slots and consume only pending ones, so they never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry <= '0;
        end else if (wr_en) begin
            entry.pending <= 1'b1;
            entry.tag     <= wr_tag;
            entry.data    <= wr_data;
        end else if (consume) begin
            entry.pending <= 1'b0;
        end
    end

    assign pending  = entry.pending;
    assign rd_match = entry.pending && (entry.tag == rd_tag);
    assign wr_match = entry.pending && (entry.tag == wr_tag);
    assign data     = entry.data;

endmodule

// File: rtl/cache_tag_mr_buffer.sv
// Tag-addressed must-read buffer: results are parked by tag and collected by a
// 1-cycle-latency lookup that either peeks or consumes the matching entry.
module cache_tag_mr_buffer
    import cache_tag_mr_pkg::*;
#(
    parameter int DATA_WIDTH = ENTRY_DATA_W,
    parameter int TAG_WIDTH  = ENTRY_TAG_W,
    parameter int DEPTH      = ENTRY_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [TAG_WIDTH-1:0]       wr_tag_i,
    input  logic [DATA_WIDTH-1:0]      wr_data_i,
    input  logic                       rd_valid_i,
    input  logic [TAG_WIDTH-1:0]       rd_tag_i,
    input  logic                       rd_consume_i,
    output logic                       rsp_valid_o,
    output logic                       rsp_hit_o,
    output logic [DATA_WIDTH-1:0]      rsp_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]                 pending;
    logic [DEPTH-1:0]                 rd_match;
    logic [DEPTH-1:0]                 wr_match;
    logic [DEPTH-1:0]                 wr_en;
    logic [DEPTH-1:0]                 consume;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data;
    logic [IDX_W-1:0]                 alloc_idx;
    logic                             wr_fire;
    logic                             hit;
    logic                             consume_hit;
    logic [DATA_WIDTH-1:0]            hit_data;
    logic [CW-1:0]                    count;

    // All decisions use pre-edge state: a slot freed this cycle is not reusable
    // until the next, and a tag written this cycle is not yet visible to lookups.
    assign full_o      = (count == CW'(DEPTH));
    assign empty_o     = (count == '0);
    assign count_o     = count;
    assign wr_ready_o  = !full_o && !(|wr_match);
    assign wr_fire     = wr_valid_i && wr_ready_o;
    assign alloc_idx   = lowest_free_idx(pending);
    assign hit         = |rd_match;
    assign consume_hit = rd_valid_i && rd_consume_i && hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign wr_en[i]   = wr_fire && (alloc_idx == IDX_W'(i));
        assign consume[i] = rd_valid_i && rd_consume_i && rd_match[i];

        cache_tag_mr_entry u_entry (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en    (wr_en[i]),
            .wr_tag   (wr_tag_i),
            .wr_data  (wr_data_i),
            .consume  (consume[i]),
            .rd_tag   (rd_tag_i),
            .pending  (pending[i]),
            .rd_match (rd_match[i]),
            .wr_match (wr_match[i]),
            .data     (data[i])
        );
    end

    // Tags are unique among pending entries, so an OR of masked data is the mux.
    always_comb begin
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_match[i]) hit_data = hit_data | data[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (wr_fire && !consume_hit) begin
            count <= count + CW'(1);
        end else if (!wr_fire && consume_hit) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= rd_valid_i;
            rsp_hit_o   <= rd_valid_i && hit;
            rsp_data_o  <= (rd_valid_i && hit) ? hit_data : '0;
        end
    end

endmodule
